// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one fetch at a time, holds the decoded word.
// Optional misaligned-redirect trap enabled with `define FETCH_MISALIGN_TRAP_EN (adds misalign_o, HALT state).
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall_i,
  input  logic [1:0]  pcsrc_EX,
  input  logic [31:0] branch_target_EX,
  input  logic [31:0] jal_target_EX,
  output logic        instr_valid,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [11:0] csr,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        misalign_o
`endif
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_HOLD, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_HOLD} state_t;
`endif

  state_t      state;
  logic [31:0] pc;
  logic [31:0] fetch_pc;
  logic        kill;
  logic        redir;
  logic [31:0] redir_tgt;
  logic [31:0] redir_pc;
  logic        req_fire;

  always_comb begin
    redir     = 1'b0;
    redir_tgt = '0;
    case (pcsrc_EX)
      2'd1: begin redir = 1'b1; redir_tgt = branch_target_EX; end
      2'd2: begin redir = 1'b1; redir_tgt = jal_target_EX;    end
      default: ;
    endcase
  end

  assign redir_pc  = redir_tgt & 32'hFFFF_FFFC;
  assign req_fire  = imem_req_valid & imem_req_ready;
  assign imem_addr = pc;

  assign opcode = instr_o[6:0];
  assign rd     = instr_o[11:7];
  assign funct3 = instr_o[14:12];
  assign rs1    = instr_o[19:15];
  assign rs2    = instr_o[24:20];
  assign funct7 = instr_o[31:25];
  assign csr    = instr_o[31:20];

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap;
  assign trap = redir & (|redir_tgt[1:0]) & (state != S_HALT);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_ISSUE;
      pc             <= RESET_PC;
      fetch_pc       <= RESET_PC;
      kill           <= 1'b0;
      instr_valid    <= 1'b0;
      instr_o        <= NOP_INSTR;
      pc_o           <= RESET_PC;
      imem_req_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_o     <= 1'b0;
`endif
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    else if (trap) begin
      state          <= S_HALT;
      misalign_o     <= 1'b1;
      pc             <= redir_pc;
      kill           <= 1'b0;
      instr_valid    <= 1'b0;
      instr_o        <= NOP_INSTR;
      imem_req_valid <= 1'b0;
    end
`endif
    else begin
      case (state)
        S_ISSUE: begin
          if (redir) begin
            pc          <= redir_pc;
            instr_valid <= 1'b0;
            instr_o     <= NOP_INSTR;
            // a fetch accepted in the redirect cycle is already wrong-path
            if (req_fire) begin
              state          <= S_WAIT;
              kill           <= 1'b1;
              imem_req_valid <= 1'b0;
            end else begin
              imem_req_valid <= 1'b1;
            end
          end else if (req_fire) begin
            state          <= S_WAIT;
            fetch_pc       <= pc;
            imem_req_valid <= 1'b0;
          end else begin
            imem_req_valid <= 1'b1;
          end
        end
        S_WAIT: begin
          if (redir) begin
            pc          <= redir_pc;
            instr_valid <= 1'b0;
            instr_o     <= NOP_INSTR;
            if (imem_rsp_valid) begin
              kill           <= 1'b0;
              state          <= S_ISSUE;
              imem_req_valid <= 1'b1;
            end else begin
              kill <= 1'b1;
            end
          end else if (imem_rsp_valid) begin
            if (kill) begin
              kill           <= 1'b0;
              state          <= S_ISSUE;
              imem_req_valid <= 1'b1;
            end else begin
              instr_o     <= imem_rsp_data;
              pc_o        <= fetch_pc;
              instr_valid <= 1'b1;
              pc          <= fetch_pc + 32'd4;
              if (stall_i) begin
                state <= S_HOLD;
              end else begin
                state          <= S_ISSUE;
                imem_req_valid <= 1'b1;
              end
            end
          end
        end
        S_HOLD: begin
          if (redir) begin
            pc             <= redir_pc;
            instr_valid    <= 1'b0;
            instr_o        <= NOP_INSTR;
            state          <= S_ISSUE;
            imem_req_valid <= 1'b1;
          end else if (!stall_i) begin
            state          <= S_ISSUE;
            imem_req_valid <= 1'b1;
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        S_HALT: ;
`endif
        default: begin
          state          <= S_ISSUE;
          imem_req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: random memory timing, stalls and redirects against a
// program-order model (next delivered pc is last pc + 4, or the latest redirect target).
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall_i;
  logic [1:0]  pcsrc_EX;
  logic [31:0] branch_target_EX, jal_target_EX;
  logic        instr_valid;
  logic [31:0] instr_o, pc_o;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [11:0] csr;
  logic [4:0]  rd, rs1, rs2;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .stall_i(stall_i), .pcsrc_EX(pcsrc_EX),
    .branch_target_EX(branch_target_EX), .jal_target_EX(jal_target_EX),
    .instr_valid(instr_valid), .instr_o(instr_o), .pc_o(pc_o),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .csr(csr),
    .rd(rd), .rs1(rs1), .rs2(rs2)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .misalign_o(misalign_o)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- memory model ----------------
  int          ready_mode;   // 0 always ready, 1 random, 2 never
  int          lat_cfg;      // 0 random 1..3, else fixed
  logic [31:0] issued[$];

  initial begin : mem
    logic        pend;
    logic [31:0] paddr;
    int          wcnt;
    pend = 1'b0; paddr = '0; wcnt = 0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) pend = 1'b0;
      else begin
        if (imem_rsp_valid) pend = 1'b0;
        if (imem_req_valid && imem_req_ready) begin
          chk("one_outstanding", 32'(pend), 32'd0);
          pend  = 1'b1;
          paddr = imem_addr;
          issued.push_back(imem_addr);
          wcnt  = (lat_cfg == 0) ? int'($urandom_range(3, 1)) : lat_cfg;
        end
      end
      #1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (pend) begin
        if (wcnt <= 1) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(paddr);
        end else wcnt--;
      end
      case (ready_mode)
        0:       imem_req_ready = 1'b1;
        1:       imem_req_ready = 1'($urandom_range(1, 0));
        default: imem_req_ready = 1'b0;
      endcase
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] exp_q[$];
  bit          halted;
  int          n_deliv = 0;

  initial begin : model
    logic [31:0] tgt;
    halted = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        exp_q  = {RESET_PC};
        halted = 1'b0;
      end else if (!halted && (pcsrc_EX == 2'd1 || pcsrc_EX == 2'd2)) begin
        tgt = (pcsrc_EX == 2'd1) ? branch_target_EX : jal_target_EX;
        exp_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
        if (tgt[1:0] != 2'b00) halted = 1'b1;
        else exp_q.push_back(tgt & 32'hFFFF_FFFC);
`else
        exp_q.push_back(tgt & 32'hFFFF_FFFC);
`endif
      end
    end
  end

  initial begin : monitor
    logic        pv;
    logic [31:0] ppc, e, w;
    pv = 1'b0; ppc = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) pv = 1'b0;
      else begin
        if (imem_req_valid) chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
        if (instr_valid && (!pv || pc_o != ppc)) begin
          n_deliv++;
          if (halted || exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_instr: got pc_o %h, want no instruction", pc_o);
          end else begin
            e = exp_q.pop_front();
            w = mem_word(e);
            chk("deliv_pc", pc_o, e);
            chk("deliv_instr", instr_o, w);
            chk("opcode", 32'(opcode), 32'(w[6:0]));
            chk("rd", 32'(rd), 32'(w[11:7]));
            chk("funct3", 32'(funct3), 32'(w[14:12]));
            chk("rs1", 32'(rs1), 32'(w[19:15]));
            chk("rs2", 32'(rs2), 32'(w[24:20]));
            chk("funct7", 32'(funct7), 32'(w[31:25]));
            chk("csr", 32'(csr), 32'(w[31:20]));
            exp_q.push_back(e + 32'd4);
          end
        end
        pv  = instr_valid;
        ppc = pc_o;
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_instr_o"}, instr_o, NOP);
    chk({tag, "_pc_o"}, pc_o, RESET_PC);
    chk({tag, "_addr"}, imem_addr, RESET_PC);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk({tag, "_misalign"}, 32'(misalign_o), 32'd0);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int          to, n;
    logic [31:0] a0;
    rst_n = 1'b0; stall_i = 1'b0; pcsrc_EX = 2'd0;
    branch_target_EX = '0; jal_target_EX = '0;
    ready_mode = 0; lat_cfg = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");

    // first fetch lands while decode is stalled, then held for 5 cycles
    tick();
    stall_i = 1'b1;
    rst_n   = 1'b1;
    issued.delete();
    to = 0;
    while (!instr_valid && to < 20) begin tick(); to++; end
    chk("t1_timeout", 32'(to >= 20), 32'd0);
    chk("t1_pc_o", pc_o, 32'h0);
    chk("t1_opcode", 32'(opcode), 32'h13);
    chk("t1_rd", 32'(rd), 32'd1);
    chk("t1_funct3", 32'(funct3), 32'd0);
    for (int k = 0; k < 5; k++) begin
      chk("t2_hold_instr", instr_o, 32'h0050_0093);
      chk("t2_hold_pc", pc_o, 32'h0);
      chk("t2_hold_noreq", 32'(imem_req_valid), 32'd0);
      tick();
    end
    stall_i = 1'b0;
    lat_cfg = 3;
    tick();
    chk("t2_req_after_stall", 32'(imem_req_valid), 32'd1);
    chk("t2_addr_after_stall", imem_addr, 32'h4);

    // jal redirect while waiting on the fetch of 8
    to = 0;
    while (issued.size() < 3 && to < 40) begin tick(); to++; end
    chk("t3_timeout", 32'(to >= 40), 32'd0);
    chk("t1_issue0", issued[0], 32'h0);
    chk("t1_issue1", issued[1], 32'h4);
    chk("t1_issue2", issued[2], 32'h8);
    pcsrc_EX = 2'd2; jal_target_EX = 32'h100;
    tick();
    pcsrc_EX = 2'd0;
    chk("t3_valid_clr", 32'(instr_valid), 32'd0);
    chk("t3_nop", instr_o, NOP);
    to = 0;
    while (!imem_req_valid && to < 20) begin tick(); to++; end
    chk("t3_req_addr", imem_addr, 32'h100);
    to = 0;
    while (!instr_valid && to < 20) begin tick(); to++; end
    chk("t3_pc_o", pc_o, 32'h100);

    // branch redirect in the same cycle as the response
    lat_cfg = 2;
    n = issued.size();
    to = 0;
    while (issued.size() == n && to < 40) begin tick(); to++; end
    tick();
    chk("t4_rsp_same_cycle", 32'(imem_rsp_valid), 32'd1);
    pcsrc_EX = 2'd1; branch_target_EX = 32'h42;
    tick();
    pcsrc_EX = 2'd0;
    chk("t4_valid_clr", 32'(instr_valid), 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("t4_misalign", 32'(misalign_o), 32'd1);
    chk("t4_halt_noreq", 32'(imem_req_valid), 32'd0);
    repeat (3) begin
      tick();
      chk("t4_halt_noreq", 32'(imem_req_valid), 32'd0);
      chk("t4_halt_novalid", 32'(instr_valid), 32'd0);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
`else
    chk("t4_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t4_addr", imem_addr, 32'h40);
    to = 0;
    while (!instr_valid && to < 20) begin tick(); to++; end
    chk("t4_pc_o", pc_o, 32'h40);
`endif

    // memory back-pressure, then reset in the middle of a fetch
    ready_mode = 2;
    to = 0;
    do begin tick(); to++; end while (!(imem_req_valid && !imem_req_ready) && to < 40);
    a0 = imem_addr;
    for (int k = 0; k < 3; k++) begin
      chk("t5_bp_valid", 32'(imem_req_valid), 32'd1);
      chk("t5_bp_addr", imem_addr, a0);
      if (k == 2) ready_mode = 0;
      if (k < 2) tick();
    end
    n = issued.size();
    tick();
    chk("t5_4th_ready", 32'(imem_req_ready), 32'd1);
    chk("t5_4th_addr", imem_addr, a0);
    tick();
    chk("t5_one_accept", 32'(issued.size()), 32'(n + 1));
    chk("t5_accept_addr", issued[n], a0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("t5_midwait");
    tick();
    rst_n = 1'b1;
    issued.delete();
    to = 0;
    while (issued.size() < 1 && to < 20) begin tick(); to++; end
    chk("t5_fetch_reset_pc", issued[0], RESET_PC);

    // wrap at the top of the address space; pcsrc 3 acts as sequential
    pcsrc_EX = 2'd2; jal_target_EX = 32'hFFFF_FFFC;
    tick();
    pcsrc_EX = 2'd3; jal_target_EX = 32'h0000_0AB0; branch_target_EX = 32'h0000_0CD0;
    issued.delete();
    to = 0;
    while (issued.size() < 3 && to < 60) begin tick(); to++; end
    pcsrc_EX = 2'd0;
    chk("t6_issue_top", issued[0], 32'hFFFF_FFFC);
    chk("t6_issue_wrap", issued[1], 32'h0);
    chk("t6_issue_seq", issued[2], 32'h4);

    // random traffic
    ready_mode = 1; lat_cfg = 0;
    for (int i = 0; i < 3000; i++) begin
      int r;
      tick();
      if (i == 1500) begin rst_n = 1'b0; tick(); rst_n = 1'b1; end
      stall_i = ($urandom_range(3, 0) == 0);
      r = int'($urandom_range(19, 0));
      pcsrc_EX = (r == 0) ? 2'd1 : (r == 1) ? 2'd2 : (r == 2) ? 2'd3 : 2'd0;
      branch_target_EX = ($urandom_range(9, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                    : ($urandom & 32'h3FF);
      jal_target_EX = $urandom & 32'hFFF;
`ifdef FETCH_MISALIGN_TRAP_EN
      branch_target_EX = branch_target_EX & 32'hFFFF_FFFC;
      jal_target_EX    = jal_target_EX & 32'hFFFF_FFFC;
`endif
    end
    pcsrc_EX = 2'd0; stall_i = 1'b0; ready_mode = 0;
    repeat (20) tick();
    chk("deliveries_seen", 32'(n_deliv > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch front end that feeds the decode/control stage. It owns the PC and issues one word fetch at a time to instruction memory over a valid/ready request and valid response interface. It holds the fetched word and splits it into the decode fields opcode, funct3, funct7, rd, rs1, rs2 and csr. It consumes pcsrc_EX, branch_target_EX and jal_target_EX from execute to redirect the PC and squash wrong-path fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, word held in the instruction register when no instruction is valid (addi x0,x0,0)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active-low
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_addr  output  32  byte address of fetch, always word aligned
imem_rsp_valid  input  1  response word valid
imem_rsp_data  input  32  response word
stall_i  input  1  decode not ready; hold the current instruction
pcsrc_EX  input  2  0 = sequential, 1 = branch target, 2 = jal target, 3 = reserved (treated as 0)
branch_target_EX  input  32  branch redirect address
jal_target_EX  input  32  jal redirect address
instr_valid  output  1  instr_o/fields hold a live instruction
instr_o  output  32  held instruction word
pc_o  output  32  address of instr_o
opcode  output  7  instr_o[6:0]
funct3  output  3  instr_o[14:12]
funct7  output  7  instr_o[31:25]
csr  output  12  instr_o[31:20]
rd  output  5  instr_o[11:7]
rs1  output  5  instr_o[19:15]
rs2  output  5  instr_o[24:20]

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=ISSUE, kill=0, instr_valid=0, instr_o=NOP_INSTR, pc_o=RESET_PC, imem_req_valid=0. All outputs take these values while reset is asserted.
- Field outputs are pure slices of instr_o (combinational, zero latency).
- Only one request may be outstanding. imem samples imem_addr only on the cycle where imem_req_valid & imem_req_ready.
- State ISSUE: imem_req_valid=1, imem_addr=pc. On ready, go to WAIT and latch fetch_pc=pc.
- State WAIT: imem_req_valid=0. On imem_rsp_valid with kill=0:
  - instr_o<=imem_rsp_data, pc_o<=fetch_pc, instr_valid<=1, pc<=fetch_pc+4.
  - Go to HOLD if stall_i, else to ISSUE.
- WAIT with kill=1: on imem_rsp_valid, discard the response, clear kill, go to ISSUE. instr_valid stays 0.
- State HOLD: instr_o, pc_o and instr_valid are held stable. When stall_i=0, go to ISSUE.
- Redirect (pcsrc_EX=1 or 2, sampled every cycle in every state):
  - pc<=target with bits[1:0] forced to 00; instr_valid<=0; instr_o<=NOP_INSTR.
  - In WAIT, set kill, or discard the response if it arrives in the same cycle.
  - In ISSUE, the request is retargeted next cycle. If that cycle also had valid&ready, the accepted fetch is killed.
  - In HOLD, go to ISSUE.
- Simultaneous events:
  - Redirect beats stall_i and beats rsp_valid.
  - While stall_i=1 with no redirect, no new instruction overwrites instr_o. ISSUE is not entered from HOLD until the stall clears.
- Latency:
  - Redirect in cycle N gives imem_addr=target with req_valid in cycle N+1.
  - Response in cycle N gives instr_valid in N+1.
  - Peak throughput is one instruction per 2 cycles (ISSUE then WAIT).
- PC arithmetic is 32-bit modular: 32'hFFFF_FFFC+4 wraps to 0.

Optional Feature:
FETCH_MISALIGN_TRAP_EN
- Defined: adds output misalign_o (1 bit, reset 0). A redirect target with bits[1:0]!=0 sets misalign_o=1 and enters state HALT. In HALT, imem_req_valid=0 and instr_valid=0 until reset; later redirects are ignored.
- Undefined: no port and no HALT state; target bits[1:0] are silently cleared.

Test Plan:
1. Reset release, memory ready=1, rsp one cycle later returning 32'h0050_0093 -> imem_addr 0,4,8 in successive ISSUE cycles; instr_valid=1 with pc_o=0, opcode=7'b0010011, rd=1, funct3=0.
2. stall_i=1 for 5 cycles after the first instruction -> instr_o and pc_o stable, no imem_req_valid while held; fetch of addr 4 issues the cycle after stall drops.
3. pcsrc_EX=2, jal_target_EX=32'h100 while in WAIT for addr 8 -> response for 8 discarded, instr_valid=0, next request addr 32'h100, next instruction has pc_o=32'h100.
4. pcsrc_EX=1, branch_target_EX=32'h42 in the same cycle as rsp_valid -> response dropped, next imem_addr=32'h40 (macro off); misalign_o=1 and no further requests (macro on).
5. imem_req_ready low for 3 cycles in ISSUE -> imem_addr held constant, one fetch accepted on the fourth cycle; rst_n pulsed low mid-WAIT -> outputs immediately at reset values, next fetch at RESET_PC.
6. pc=32'hFFFF_FFFC fetched -> next imem_addr=32'h0; pcsrc_EX=3 -> behaves as sequential.
